phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Five-phase instruction sequencer for the 16-bit core. Phases: P1 fetch, P2 decode, P3 execute, P4 memory, P5 writeback.
//  Drives fetch/memory handshakes, PC/IR strobes and register-file write enable. Gates the write-address decoder's
//  write_order into reg_we during P5 only. Handles HLT, bus stall timeout and retired-instruction counting.
// PARAMETERS
//  STALL_LIMIT  255  max extra wait cycles for an ack; waiting cycle index k=0..STALL_LIMIT, no ack at k=STALL_LIMIT -> ERR
//  CNT_W        16   width of instr_count
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  run          in   1      level; start/continue execution
//  instr        in   16     IR contents, valid from P2; op1=[15:14], op3=[7:4]
//  write_order  in   1      from write-address decoder
//  fetch_ack    in   1      instruction memory ack
//  mem_ack      in   1      data memory ack
//  phase        out  3      current phase 0..4 (P1..P5), 3'b000 when !active
//  active       out  1      1 while in P1..P5
//  fetch_req    out  1      instruction fetch request
//  ir_load      out  1      IR load strobe
//  pc_inc       out  1      PC increment strobe
//  mem_req      out  1      data memory request
//  mem_we       out  1      data memory write (valid with mem_req)
//  reg_we       out  1      register-file write enable
//  halted       out  1      sticky HLT indicator
//  bus_err      out  1      sticky stall-timeout indicator
//  instr_count  out  CNT_W  retired instructions, wraps
// BEHAVIOUR
//  States: IDLE, P1..P5, HALT, ERR. Outputs combinational from state/inputs; state, stall counter, instr_count registered.
//  Reset (rst_n low, async): state IDLE, stall counter 0, instr_count 0; every output 0 immediately.
//  IDLE: run=1 -> P1 next edge; else stay.
//  P1: fetch_req=1. ir_load=fetch_ack. fetch_ack=1 -> P2. No ack: stall++; no ack at k=STALL_LIMIT -> ERR.
//  P2: pc_inc=1 (one cycle). instr==HLT (op1=2'b11, op3=4'hF) -> HALT, instr_count++; else -> P3.
//  P3: one cycle -> P4.
//  P4: op1 in {00 LD, 01 ST}: mem_req=1, mem_we=(op1==01); stay until mem_ack; timeout as P1 -> ERR.
//      Other op1: mem_req=0, single cycle. -> P5.
//  P5: reg_we = write_order & (op1!=2'b01); single cycle; instr_count++ (wrap 2^CNT_W-1 -> 0); run ? P1 : IDLE.
//  Stall counter cleared on every entry to P1 and P4; width sized for STALL_LIMIT.
//  run low mid-instruction: current instruction completes through P5, then IDLE.
//  Acks sampled only while matching req is high; acks otherwise ignored. Ack in first cycle -> one-cycle phase.
//  HALT: halted=1, all other strobes 0, run ignored; exit only via rst_n.
//  ERR: bus_err=1, all strobes 0, requests dropped; exit only via rst_n.
//  Reset mid-handshake: fetch_req/mem_req drop asynchronously; no write issued.
// TESTING
//  1 run=1, instr=16'hC000 (ADD), write_order=1, acks tied 1 -> phase 0,1,2,3,4 over 5 cycles; reg_we=1 only in P5;
//    instr_count=1; next P1 on cycle 6.
//  2 instr=16'h0800 (LD), mem_ack after 3 low cycles -> P4 lasts 4 cycles, mem_req=1 throughout, mem_we=0, reg_we=1 in P5.
//  3 instr=16'h4000 (ST), write_order=1 -> mem_we=1 in P4, reg_we=0 in P5.
//  4 instr=16'hC0F0 (HLT) -> after P2 halted=1, phase=0, active=0, instr_count=1; run toggling no effect; rst_n clears.
//  5 STALL_LIMIT=4, fetch_ack held 0 -> ERR after 5 P1 cycles, bus_err=1, fetch_req=0; rst_n low clears all.
//  6 CNT_W=4, 16 ADDs -> instr_count wraps 15->0; rst_n low in P4 of LD -> mem_req=0 same cycle, state IDLE.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | Module : phase_sequencer_if                                              |
// | Desc   : Fetch and data-memory request/ack handshake bundle.             |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface phase_sequencer_if;
    logic fetch_req;
    logic fetch_ack;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output fetch_req,
        output mem_req,
        output mem_we,
        input  fetch_ack,
        input  mem_ack
    );

    modport slave (
        input  fetch_req,
        input  mem_req,
        input  mem_we,
        output fetch_ack,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/phase_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : phase_sequencer                                                 |
// | Desc   : Five-phase fetch/decode/execute/memory/writeback sequencer.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module phase_sequencer #(
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             run,
    input  wire logic [15:0]      instr,
    input  wire logic             write_order,
    phase_sequencer_if.master     bus,
    output logic [2:0]            phase,
    output logic                  active,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  reg_we,
    output logic                  halted,
    output logic                  bus_err,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_P5   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0] op1;
    logic [3:0] op3;
    logic       is_hlt;
    logic       is_mem;
    logic       unused_instr_bits;

    assign op1               = instr[15:14];
    assign op3               = instr[7:4];
    assign is_hlt            = (op1 == 2'b11) && (op3 == 4'hF);
    assign is_mem            = (op1 == 2'b00) || (op1 == 2'b01);
    assign unused_instr_bits = ^{instr[13:8], instr[3:0]};
    assign instr_count       = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stall_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_d       = stall_q;
        count_d       = count_q;
        phase         = 3'd0;
        active        = 1'b0;
        bus.fetch_req = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        reg_we        = 1'b0;
        halted        = 1'b0;
        bus_err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_P1;
                    stall_d = '0;
                end
            end
            S_P1: begin
                phase         = 3'd0;
                active        = 1'b1;
                bus.fetch_req = 1'b1;
                ir_load       = bus.fetch_ack;
                // Timeout fires on the last permitted waiting cycle without an ack.
                if (bus.fetch_ack) begin
                    state_d = S_P2;
                end else if (stall_q == STALL_MAX) begin
                    state_d = S_ERR;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_P2: begin
                phase  = 3'd1;
                active = 1'b1;
                pc_inc = 1'b1;
                if (is_hlt) begin
                    state_d = S_HALT;
                    count_d = count_q + 1'b1;
                end else begin
                    state_d = S_P3;
                end
            end
            S_P3: begin
                phase   = 3'd2;
                active  = 1'b1;
                state_d = S_P4;
                stall_d = '0;
            end
            S_P4: begin
                phase  = 3'd3;
                active = 1'b1;
                if (is_mem) begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (op1 == 2'b01);
                    if (bus.mem_ack) begin
                        state_d = S_P5;
                    end else if (stall_q == STALL_MAX) begin
                        state_d = S_ERR;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    state_d = S_P5;
                end
            end
            S_P5: begin
                phase   = 3'd4;
                active  = 1'b1;
                reg_we  = write_order & (op1 != 2'b01);
                count_d = count_q + 1'b1;
                if (run) begin
                    state_d = S_P1;
                    stall_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
                bus_err = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : tb_phase_sequencer                                              |
// | Desc   : Randomized self-checking bench with per-instruction phase model.|
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_phase_sequencer;

    localparam int LIM = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic [15:0]   instr = 16'h0000;
    logic          write_order = 1'b0;
    logic [2:0]    phase;
    logic          active, ir_load, pc_inc, reg_we, halted, bus_err;
    logic [CW-1:0] instr_count;

    phase_sequencer_if bus ();

    phase_sequencer #(.STALL_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instr       (instr),
        .write_order (write_order),
        .bus         (bus.master),
        .phase       (phase),
        .active      (active),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .reg_we      (reg_we),
        .halted      (halted),
        .bus_err     (bus_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // {phase, active, fetch_req, ir_load, pc_inc, mem_req, mem_we, reg_we, halted, bus_err}
    wire [12:0] obs = {phase, active, bus.fetch_req, ir_load, pc_inc,
                       bus.mem_req, bus.mem_we, reg_we, halted, bus_err};
    logic [12:0] e;
    int checks   = 0;
    int failures = 0;
    int m_count  = 0;

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        m_count = 0;
        e = 13'b0;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_outputs obs=%b exp=%b", obs, e); end
        checks++;
        if (instr_count !== CW'(m_count)) begin failures++; $display("FAIL reset_count obs=%0d exp=%0d", instr_count, m_count); end
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
    endtask

    task automatic idle_cycle(input logic r);
        @(negedge clk);
        run = r;
        bus.fetch_ack = 1'($urandom);
        bus.mem_ack   = 1'($urandom);
        #1;
        e = 13'b0;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL idle_outputs obs=%b exp=%b", obs, e); end
        checks++;
        if (instr_count !== CW'(m_count)) begin failures++; $display("FAIL idle_count obs=%0d exp=%0d", instr_count, m_count); end
    endtask

    // status: 0 retired, 1 halted, 2 bus error, 3 reset during P4
    task automatic do_instr(input logic [15:0] ins, input logic wo, input int df, input int dm,
                            input logic run_next, input logic abort_p4, output int status);
        logic [1:0] op1;
        logic       is_hlt, is_mem;
        op1    = ins[15:14];
        is_hlt = (op1 == 2'b11) && (ins[7:4] == 4'hF);
        is_mem = (op1 == 2'b00) || (op1 == 2'b01);
        status = 0;

        for (int k = 0; k <= LIM; k++) begin
            @(negedge clk);
            bus.fetch_ack = (k == df);
            bus.mem_ack   = 1'($urandom);
            run           = 1'($urandom);
            instr         = 16'($urandom);
            write_order   = 1'($urandom);
            #1;
            e = {3'd0, 1'b1, 1'b1, (k == df), 6'b0};
            checks++;
            if (obs !== e) begin failures++; $display("FAIL p1_outputs k=%0d obs=%b exp=%b", k, obs, e); end
            checks++;
            if (instr_count !== CW'(m_count)) begin failures++; $display("FAIL p1_count obs=%0d exp=%0d", instr_count, m_count); end
            if (k == df) break;
        end
        if (df > LIM) begin
            @(negedge clk);
            bus.fetch_ack = 1'($urandom);
            #1;
            e = 13'b1;
            checks++;
            if (obs !== e) begin failures++; $display("FAIL fetch_timeout obs=%b exp=%b", obs, e); end
            status = 2;
            return;
        end

        @(negedge clk);
        instr         = ins;
        bus.fetch_ack = 1'($urandom);
        bus.mem_ack   = 1'($urandom);
        run           = 1'($urandom);
        #1;
        e = {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL p2_outputs obs=%b exp=%b", obs, e); end
        if (is_hlt) begin
            m_count = (m_count + 1) % (1 << CW);
            status  = 1;
            return;
        end

        @(negedge clk);
        bus.fetch_ack = 1'($urandom);
        bus.mem_ack   = 1'($urandom);
        run           = 1'($urandom);
        #1;
        e = {3'd2, 1'b1, 8'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL p3_outputs obs=%b exp=%b", obs, e); end

        if (is_mem) begin
            for (int k = 0; k <= LIM; k++) begin
                @(negedge clk);
                bus.mem_ack   = (k == dm);
                bus.fetch_ack = 1'($urandom);
                run           = 1'($urandom);
                #1;
                e = {3'd3, 1'b1, 3'b0, 1'b1, (op1 == 2'b01), 3'b0};
                checks++;
                if (obs !== e) begin failures++; $display("FAIL p4_mem_outputs k=%0d obs=%b exp=%b", k, obs, e); end
                if (abort_p4) begin
                    pulse_reset();
                    status = 3;
                    return;
                end
                if (k == dm) break;
            end
            if (dm > LIM) begin
                @(negedge clk);
                bus.mem_ack = 1'($urandom);
                #1;
                e = 13'b1;
                checks++;
                if (obs !== e) begin failures++; $display("FAIL mem_timeout obs=%b exp=%b", obs, e); end
                status = 2;
                return;
            end
        end else begin
            @(negedge clk);
            bus.mem_ack   = 1'($urandom);
            bus.fetch_ack = 1'($urandom);
            run           = 1'($urandom);
            #1;
            e = {3'd3, 1'b1, 8'b0};
            checks++;
            if (obs !== e) begin failures++; $display("FAIL p4_alu_outputs obs=%b exp=%b", obs, e); end
        end

        @(negedge clk);
        write_order   = wo;
        run           = run_next;
        bus.fetch_ack = 1'($urandom);
        bus.mem_ack   = 1'($urandom);
        #1;
        e = {3'd4, 1'b1, 5'b0, (wo && (op1 != 2'b01)), 2'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL p5_outputs obs=%b exp=%b", obs, e); end
        checks++;
        if (instr_count !== CW'(m_count)) begin failures++; $display("FAIL p5_count obs=%0d exp=%0d", instr_count, m_count); end
        m_count = (m_count + 1) % (1 << CW);
    endtask

    task automatic test_reset();
        pulse_reset();
    endtask

    task automatic test_add();
        int st;
        idle_cycle(1'b1);
        do_instr(16'hC000, 1'b1, 0, 0, 1'b1, 1'b0, st);
        do_instr(16'hC000, 1'b1, 0, 0, 1'b0, 1'b0, st);
        idle_cycle(1'b0);
    endtask

    task automatic test_ld();
        int st;
        idle_cycle(1'b1);
        do_instr(16'h0800, 1'b1, 0, 3, 1'b0, 1'b0, st);
        idle_cycle(1'b0);
    endtask

    task automatic test_st();
        int st;
        idle_cycle(1'b1);
        do_instr(16'h4000, 1'b1, int'($urandom_range(0, LIM)), 1, 1'b0, 1'b0, st);
        idle_cycle(1'b0);
    endtask

    task automatic test_random();
        int st;
        logic [15:0] ins;
        idle_cycle(1'b1);
        for (int i = 0; i < 30; i++) begin
            ins = 16'($urandom);
            if (ins[15:14] == 2'b11 && ins[7:4] == 4'hF) ins[4] = 1'b0;
            do_instr(ins, 1'($urandom), int'($urandom_range(0, LIM)), int'($urandom_range(0, LIM)),
                     ($urandom_range(0, 3) != 0), 1'b0, st);
            if (run == 1'b0) begin
                idle_cycle(1'b0);
                idle_cycle(1'b1);
            end
        end
        if (run == 1'b1) pulse_reset();
    endtask

    task automatic test_wrap();
        int st;
        pulse_reset();
        idle_cycle(1'b1);
        for (int i = 0; i < 16; i++) begin
            do_instr(16'hC000, 1'b1, 0, 0, (i != 15), 1'b0, st);
        end
        idle_cycle(1'b0);
        checks++;
        if (instr_count !== '0) begin failures++; $display("FAIL wrap_count obs=%0d exp=0", instr_count); end
    endtask

    task automatic test_reset_mid_ld();
        int st;
        idle_cycle(1'b1);
        do_instr(16'h0800, 1'b1, 0, 3, 1'b1, 1'b1, st);
        idle_cycle(1'b0);
    endtask

    task automatic test_halt();
        int st;
        idle_cycle(1'b1);
        do_instr(16'hC0F0, 1'b1, 1, 0, 1'b1, 1'b0, st);
        checks++;
        if (st != 1) begin failures++; $display("FAIL halt_entry status=%0d exp=1", st); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run           = 1'($urandom);
            bus.fetch_ack = 1'($urandom);
            bus.mem_ack   = 1'($urandom);
            #1;
            e = {3'd0, 8'b0, 1'b1, 1'b0};
            checks++;
            if (obs !== e) begin failures++; $display("FAIL halt_outputs obs=%b exp=%b", obs, e); end
            checks++;
            if (instr_count !== CW'(m_count)) begin failures++; $display("FAIL halt_count obs=%0d exp=%0d", instr_count, m_count); end
        end
        pulse_reset();
    endtask

    task automatic test_stall_timeout();
        int st;
        idle_cycle(1'b1);
        do_instr(16'hC000, 1'b0, LIM + 1, 0, 1'b1, 1'b0, st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run           = 1'($urandom);
            bus.fetch_ack = 1'($urandom);
            bus.mem_ack   = 1'($urandom);
            #1;
            e = 13'b1;
            checks++;
            if (obs !== e) begin failures++; $display("FAIL err_sticky obs=%b exp=%b", obs, e); end
        end
        pulse_reset();
    endtask

    initial begin
        bus.fetch_ack = 1'b0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_add();
        test_ld();
        test_st();
        test_random();
        test_wrap();
        test_reset_mid_ld();
        test_halt();
        test_stall_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
